// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: active-low segment
// encodings ({g..a}) and the width helper used to size the scan counters.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 blank.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Constant lookup of the segment pattern for one BCD digit
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-aligned
// shadow-buffer commits. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic [6:0]                seg_out,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    logic [CNT_W-1:0]          div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]          digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0]   active_q, active_d;
    logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
    logic                      pending_valid_q, pending_valid_d;
    logic                      load_ready_q, load_ready_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [6:0]                seg_q, seg_d;
    logic                      frame_done_q, frame_done_d;
    logic                      tick_s, boundary_s, accept_s, commit_s, blank_s;
    logic [3:0]                digit_s;
    logic [6:0]                dec_seg_s;

    // Scan counters, shadow-buffer handshake and next output values
    always_comb begin
        tick_s     = (div_cnt_q == CNT_MAX);
        boundary_s = tick_s && (digit_idx_q == IDX_MAX);
        accept_s   = load_valid && load_ready_q;
        commit_s   = boundary_s && pending_valid_q;

        div_cnt_d   = tick_s ? CNT_ZERO : (div_cnt_q + CNT_ONE);
        digit_idx_d = digit_idx_q;
        if (tick_s) begin
            digit_idx_d = (digit_idx_q == IDX_MAX) ? IDX_ZERO : (digit_idx_q + IDX_ONE);
        end else begin
            digit_idx_d = digit_idx_q;
        end

        active_d        = commit_s ? pending_q : active_q;
        pending_d       = accept_s ? value_in : pending_q;
        pending_valid_d = pending_valid_q;
        // accept and commit are exclusive: accept needs the buffer empty
        if (commit_s) begin
            pending_valid_d = 1'b0;
        end else if (accept_s) begin
            pending_valid_d = 1'b1;
        end else begin
            pending_valid_d = pending_valid_q;
        end
        load_ready_d = !pending_valid_d;

        digit_s = active_d[{digit_idx_d, 2'b00} +: 4];

        an_d  = {NUM_DIGITS{1'b1}};
        seg_d = SEG_BLANK;
        // Slot cycle 0 keeps all anodes off as dead-time
        if (div_cnt_d != CNT_ZERO) begin
            an_d[digit_idx_d] = 1'b0;
            seg_d = blank_s ? SEG_BLANK : dec_seg_s;
        end else begin
            an_d  = {NUM_DIGITS{1'b1}};
            seg_d = SEG_BLANK;
        end

        frame_done_d = (div_cnt_d == CNT_MAX) && (digit_idx_d == IDX_MAX);
    end

    bcd_to_7seg u_dec (
        .bcd_i (digit_s),
        .seg_o (dec_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask_q, blank_mask_d;

    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic seen;
        lz_mask = {NUM_DIGITS{1'b0}};
        seen    = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (v[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            lz_mask[i] = !seen && (i != 0);
        end
    endfunction

    // Blank mask follows the active buffer, so it only changes on commit
    always_comb begin
        blank_mask_d = commit_s ? lz_mask(pending_q) : blank_mask_q;
        blank_s      = blank_mask_d[digit_idx_d];
    end

    // Blank mask register; reset mask matches an all-zero active value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_mask_q <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
        end else begin
            blank_mask_q <= blank_mask_d;
        end
    end
`else
    assign blank_s = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q       <= CNT_ZERO;
            digit_idx_q     <= IDX_ZERO;
            active_q        <= {(4*NUM_DIGITS){1'b0}};
            pending_q       <= {(4*NUM_DIGITS){1'b0}};
            pending_valid_q <= 1'b0;
            load_ready_q    <= 1'b1;
            an_q            <= {NUM_DIGITS{1'b1}};
            seg_q           <= SEG_BLANK;
            frame_done_q    <= 1'b0;
        end else begin
            div_cnt_q       <= div_cnt_d;
            digit_idx_q     <= digit_idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            load_ready_q    <= load_ready_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized/directed bench for seg_scan_ctrl (4 digits, 4 clocks per slot)
// against a time-indexed reference model of the scan and shadow buffer.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int NR = N * R;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lv;
    logic        load_ready;
    logic [15:0] vin;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since reset, displayed value, shadow buffer
    int          t;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    logic        m_pv;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (lv),
        .load_ready (load_ready),
        .value_in   (vin),
        .an_out     (an_out),
        .seg_out    (seg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [3:0] nib;
        int hi;
        nib = v[4*d +: 4];
        hi  = 0;
        for (int i = 0; i < N; i++) begin
            if (v[4*i +: 4] != 4'd0) hi = i;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (d > hi) return 7'h7F;
`endif
        return seg_tab[nib];
    endfunction

    task automatic model_reset();
        t      = 0;
        m_act  = 16'h0000;
        m_pend = 16'h0000;
        m_pv   = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge
    task automatic cycle();
        int pos;
        int dig;
        logic [3:0] e_an;
        logic bnd;
        logic acc;
        @(negedge clk);
        pos  = t % R;
        dig  = (t / R) % N;
        e_an = 4'hF;
        if (pos != 0) e_an[dig] = 1'b0;
        chk("an_out", {12'h000, an_out}, {12'h000, e_an});
        if (pos != 0) chk("seg_out", {9'h000, seg_out}, {9'h000, exp_seg(m_act, dig)});
        chk("frame_done", {15'h0000, frame_done}, {15'h0000, ((t % NR) == NR - 1)});
        chk("load_ready", {15'h0000, load_ready}, {15'h0000, !m_pv});
        @(posedge clk);
        bnd = ((t % NR) == NR - 1);
        acc = lv && !m_pv;
        if (bnd && m_pv) begin
            m_act = m_pend;
            m_pv  = 1'b0;
        end
        if (acc) begin
            m_pend = vin;
            m_pv   = 1'b1;
        end
        t++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_once(input logic [15:0] v);
        int n;
        n   = 0;
        lv  = 1'b1;
        vin = v;
        while (lv && n < 100) begin
            if (!m_pv) begin
                cycle();
                lv = 1'b0;
            end else begin
                cycle();
            end
            n++;
        end
        lv = 1'b0;
        chk("load_wait", {15'h0000, (n < 100)}, 16'h0001);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        lv    = 1'b0;
        vin   = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", {12'h000, an_out}, 16'h000F);
        chk("rst_seg", {9'h000, seg_out}, 16'h007F);
        rst_n = 1'b1;

        // Idle scan of the all-zero reset value, then a single load
        run(NR + 3);
        load_once(16'h1234);
        run(2 * NR + 2);

        // Back-to-back loads: the second waits for the first to commit
        load_once(16'h1111);
        load_once(16'h2222);
        run(2 * NR);

        // Load offered exactly on a boundary cycle with the buffer empty
        n = 0;
        while (!(((t % NR) == NR - 1) && !m_pv) && n < 100) begin
            cycle();
            n++;
        end
        chk("bnd_reach", {15'h0000, (n < 100)}, 16'h0001);
        lv  = 1'b1;
        vin = 16'h5678;
        cycle();
        lv  = 1'b0;
        chk("bnd_pending", {15'h0000, m_pv}, 16'h0001);
        run(2 * NR + 1);

        // Asynchronous reset mid-scan discards pending data
        load_once(16'h9999);
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_an", {12'h000, an_out}, 16'h000F);
        chk("arst_seg", {9'h000, seg_out}, 16'h007F);
        chk("arst_rdy", {15'h0000, load_ready}, 16'h0001);
        chk("arst_fd", {15'h0000, frame_done}, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(2 * NR + 1);

        // Invalid BCD digits blank; zero digits decode normally
        load_once(16'h00AF);
        run(2 * NR + 2);
        load_once(16'h0070);
        run(2 * NR + 2);
        load_once(16'h0000);
        run(2 * NR + 2);

        // Randomized valid/data traffic
        for (int i = 0; i < 600; i++) begin
            lv  = 1'($urandom_range(0, 1));
            vin = 16'($urandom);
            cycle();
        end
        lv = 1'b0;
        run(2 * NR + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
